register_bus_master: RTL and testbench



---
 rtl/reg_bus_pkg.sv | 22 ++
 rtl/register_bus_master_if.sv | 43 ++++
 rtl/register_bus_master_decoder.sv | 16 +
 rtl/register_bus_master.sv | 94 +++++++++
 tb/tb_register_bus_master.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the register bus master.
//   state_t        controller states
//   TurnCycles     idle bus cycles inserted after every bus cycle
//   resp_zero_bit  value driven into respData for unanswered/out-of-range reads
package reg_bus_pkg;

    typedef enum logic [2:0] {
        Idle,
        Write,
        Read,
        Turn,
        Resp
    } state_t;

    localparam int TurnCycles = 1;

    // Replicated to BitWidth by the user; keeps the package width-agnostic.
    function automatic logic resp_zero_bit();
        return 1'b0;
    endfunction

endpackage

// File: rtl/register_bus_master_if.sv
// Core-side request/response channels and the shared register bus.
//   master modport : controller view (drives reqReady, resp*, bus* outputs)
//   slave modport  : core + register bank view (the opposite directions)
// Optional macro REG_BUS_ERROR_EN adds respError and writeError.
interface register_bus_master_if #(
    parameter int BitWidth   = 32,
    parameter int SlaveCount = 32,
    parameter int AddrWidth  = $clog2(SlaveCount)
);
    logic                  reqValid;
    logic                  reqReady;
    logic                  reqWrite;
    logic [AddrWidth-1:0]  reqAddr;
    logic [BitWidth-1:0]   reqData;
    logic                  respValid;
    logic                  respReady;
    logic [BitWidth-1:0]   respData;
    logic [SlaveCount-1:0] busEnable;
    logic                  busWrite;
    logic [BitWidth-1:0]   busWData;
    logic [BitWidth-1:0]   busRData;
`ifdef REG_BUS_ERROR_EN
    logic                  respError;
    logic                  writeError;
`endif

    modport master (
        input  reqValid, reqWrite, reqAddr, reqData, respReady, busRData,
`ifdef REG_BUS_ERROR_EN
        output respError, writeError,
`endif
        output reqReady, respValid, respData, busEnable, busWrite, busWData
    );

    modport slave (
        output reqValid, reqWrite, reqAddr, reqData, respReady, busRData,
`ifdef REG_BUS_ERROR_EN
        input  respError, writeError,
`endif
        input  reqReady, respValid, respData, busEnable, busWrite, busWData
    );

endinterface

// File: rtl/register_bus_master_decoder.sv
// onehot_decoder: binary index -> one-hot select.
//   index  : binary slave index (Width bits)
//   onehot : Count-bit select; all zero when index >= Count
module onehot_decoder #(
    parameter int Width = 5,
    parameter int Count = 32
) (
    input  logic [Width-1:0] index,
    output logic [Count-1:0] onehot
);
    // Only indices 0..Count-1 have a matching bit, so an out-of-range
    // index naturally decodes to all zeros.
    for (genvar i = 0; i < Count; i++) begin : g_bit
        assign onehot[i] = (index == Width'(i));
    end
endmodule

// File: rtl/register_bus_master.sv
// register_bus_master: issues single read/write transactions to a bank of
// SlaveCount registers over a shared bus, with an idle turnaround cycle
// after every bus cycle so no two slaves drive busRData back to back.
// Ports:
//   clock, reset : single clock, synchronous active-high reset
//   bus          : register_bus_master_if.master (request, response, bus)
// Optional macro REG_BUS_ERROR_EN: adds respError / writeError flags.
module register_bus_master
    import reg_bus_pkg::*;
#(
    parameter int BitWidth   = 32,
    parameter int SlaveCount = 32,
    parameter int AddrWidth  = $clog2(SlaveCount)
) (
    input  logic                  clock,
    input  logic                  reset,
    register_bus_master_if.master bus
);
    state_t                state, nextState;
    logic [AddrWidth-1:0]  addrQ;
    logic [BitWidth-1:0]   dataQ;
    logic                  writeQ;
    logic [BitWidth-1:0]   respDataQ;
    logic [3:0]            turnCnt;
    logic [SlaveCount-1:0] decoded;
    logic                  addrOk;
    logic                  accept;

    onehot_decoder #(.Width(AddrWidth), .Count(SlaveCount)) u_dec (
        .index  (addrQ),
        .onehot (decoded)
    );

    // Decoder yields a bit only for an in-range index.
    assign addrOk = |decoded;
    assign accept = bus.reqValid && (state == Idle);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= Idle;
            addrQ     <= '0;
            dataQ     <= '0;
            writeQ    <= 1'b0;
            respDataQ <= '0;
            turnCnt   <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                addrQ  <= bus.reqAddr;
                dataQ  <= bus.reqData;
                writeQ <= bus.reqWrite;
            end
            // An unselected bus floats, so never sample it for out-of-range reads.
            if (state == Read)
                respDataQ <= addrOk ? bus.busRData : {BitWidth{resp_zero_bit()}};
            turnCnt <= (state == Turn) ? turnCnt + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            Idle:    if (bus.reqValid) nextState = bus.reqWrite ? Write : Read;
            Write:   nextState = Turn;
            Read:    nextState = Turn;
            Turn:    if (turnCnt == 4'(TurnCycles - 1)) nextState = writeQ ? Idle : Resp;
            Resp:    if (bus.respReady) nextState = Idle;
            default: nextState = Idle;
        endcase
    end

    // Outputs decode straight from registered state: one bus cycle per
    // transaction, zero everywhere else, so wdata never leaks.
    assign bus.reqReady  = (state == Idle);
    assign bus.busEnable = (state == Write || state == Read) ? decoded : '0;
    assign bus.busWrite  = (state == Write) && addrOk;
    assign bus.busWData  = bus.busWrite ? dataQ : '0;
    assign bus.respValid = (state == Resp);
    assign bus.respData  = respDataQ;

`ifdef REG_BUS_ERROR_EN
    logic errQ;

    always_ff @(posedge clock) begin
        if (reset)               errQ <= 1'b0;
        else if (state == Write) errQ <= !addrOk;
        else if (state == Read)  errQ <= !addrOk || $isunknown(bus.busRData);
    end

    assign bus.respError  = (state == Resp) && errQ;
    assign bus.writeError = (state == Turn) && writeQ && errQ;
`endif

endmodule

// File: tb/tb_register_bus_master.sv
module tb_register_bus_master;
    localparam int BW = 32;
    localparam int SC = 20;
    localparam int AW = $clog2(SC);

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    register_bus_master_if #(.BitWidth(BW), .SlaveCount(SC), .AddrWidth(AW)) bif ();

    register_bus_master #(.BitWidth(BW), .SlaveCount(SC), .AddrWidth(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    // Register bank driven only by the DUT's bus signals.
    logic [BW-1:0] slaveMem [SC];
    always @(posedge clock)
        if (bif.busWrite)
            for (int i = 0; i < SC; i++)
                if (bif.busEnable[i]) slaveMem[i] <= bif.busWData;

    always_comb begin
        bif.busRData = 32'hBAD0BAD0;   // junk while nobody drives the line
        for (int i = 0; i < SC; i++)
            if (bif.busEnable[i]) bif.busRData = slaveMem[i];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // A request accepted in cycle a owns the bus in cycle a+1, turnaround in
    // a+2, then a write is finished and a read presents its response from a+3
    // until respReady is seen.
    int            cyc = 0;
    bit            live = 0;
    bit            mAct = 0;
    int            mAcc, mAddr;
    bit            mWr;
    logic [BW-1:0] mData;
    logic [BW-1:0] mMem [SC];
    logic [BW-1:0] mResp = '0;
    bit            prevEn = 0;

    always @(negedge clock) begin
        logic [SC-1:0] eEn;
        logic          eWe, eRv, eRdy;
        logic [BW-1:0] eWd;
        int            off;
        eEn = '0; eWe = 0; eRv = 0; eRdy = 1; eWd = '0; off = 0;
        if (live) begin
            if (mAct) begin
                off  = cyc - mAcc;
                eRdy = 0;
                if (off == 1) begin
                    if (mAddr < SC) eEn[mAddr] = 1'b1;
                    eWe = mWr && (mAddr < SC);
                    if (eWe) eWd = mData;
                end else if (off >= 3) begin
                    eRv = 1;
                end
            end
            chk("reqReady",  64'(bif.reqReady),  64'(eRdy));
            chk("busEnable", 64'(bif.busEnable), 64'(eEn));
            chk("busWrite",  64'(bif.busWrite),  64'(eWe));
            chk("busWData",  64'(bif.busWData),  64'(eWd));
            chk("respValid", 64'(bif.respValid), 64'(eRv));
            if (eRv) chk("respData", 64'(bif.respData), 64'(mResp));
`ifdef REG_BUS_ERROR_EN
            if (eRv) chk("respError", 64'(bif.respError), 64'(mAddr >= SC));
            chk("writeError", 64'(bif.writeError), 64'(mAct && off == 2 && mWr && mAddr >= SC));
`endif
            chk("enable gap", 64'(prevEn && (bif.busEnable != '0)), 64'(0));
        end
        prevEn = (bif.busEnable != '0);

        // advance the model across the coming edge
        if (reset) begin
            mAct = 0; mResp = '0; live = 1;
        end else if (live) begin
            if (mAct) begin
                if (off == 1) begin
                    if (mWr && mAddr < SC) mMem[mAddr] = mData;
                    if (!mWr) mResp = (mAddr < SC) ? mMem[mAddr] : '0;
                end
                if (mWr && off == 2) mAct = 0;
                if (!mWr && off >= 3 && bif.respReady) mAct = 0;
            end else if (bif.reqValid) begin
                mAct = 1; mAcc = cyc; mWr = bif.reqWrite;
                mAddr = int'(bif.reqAddr); mData = bif.reqData;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    // Drives a request one cycle after the call and returns 1ns into the
    // cycle following acceptance (cycle 1 of that transaction).
    task automatic send(input bit wr, input int addr, input logic [BW-1:0] data);
        bit ok = 0;
        @(posedge clock); #1;
        bif.reqValid = 1; bif.reqWrite = wr; bif.reqAddr = AW'(addr); bif.reqData = data;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clock);
            if (bif.reqReady) ok = 1;
        end
        if (!ok) chk("accept timeout", 64'(0), 64'(1));
        @(posedge clock); #1;
        bif.reqValid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit sawResp;
        reset = 1;
        bif.reqValid = 0; bif.reqWrite = 0; bif.reqAddr = '0; bif.reqData = '0;
        bif.respReady = 1;
        repeat (3) @(posedge clock);
        #1 reset = 0;

        @(negedge clock);
        chk("rst reqReady",  64'(bif.reqReady),  64'(1));
        chk("rst respValid", 64'(bif.respValid), 64'(0));
        chk("rst busEnable", 64'(bif.busEnable), 64'(0));
        chk("rst busWrite",  64'(bif.busWrite),  64'(0));
        chk("rst busWData",  64'(bif.busWData),  64'(0));
        chk("rst respData",  64'(bif.respData),  64'(0));

        // write slave 5
        send(1, 5, 32'hDEADBEEF);
        @(negedge clock);
        chk("wr c1 enable", 64'(bif.busEnable), 64'h20);
        chk("wr c1 strobe", 64'(bif.busWrite),  64'(1));
        chk("wr c1 wdata",  64'(bif.busWData),  64'hDEADBEEF);
        @(negedge clock);
        chk("wr c2 enable", 64'(bif.busEnable), 64'(0));
        chk("wr c2 ready",  64'(bif.reqReady),  64'(0));
        @(negedge clock);
        chk("wr c3 ready",  64'(bif.reqReady),  64'(1));
        chk("slave5",       64'(slaveMem[5]),   64'hDEADBEEF);

        // read slave 5, respReady held high
        send(0, 5, '0);
        @(negedge clock); chk("rd c1 valid", 64'(bif.respValid), 64'(0));
        @(negedge clock); chk("rd c2 valid", 64'(bif.respValid), 64'(0));
        @(negedge clock);
        chk("rd c3 valid", 64'(bif.respValid), 64'(1));
        chk("rd c3 data",  64'(bif.respData),  64'hDEADBEEF);
        @(negedge clock); chk("rd c4 ready", 64'(bif.reqReady), 64'(1));

        // preload slave 7, then read it with a stalled consumer
        send(1, 7, 32'h12345678);
        repeat (3) @(negedge clock);
        @(posedge clock); #1 bif.respReady = 0;
        send(0, 7, '0);
        repeat (3) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            chk("stall valid", 64'(bif.respValid), 64'(1));
            chk("stall data",  64'(bif.respData),  64'h12345678);
            chk("stall ready", 64'(bif.reqReady),  64'(0));
            if (i < 3) @(negedge clock);
        end
        @(posedge clock); #1 bif.respReady = 1;
        @(negedge clock); chk("release ready", 64'(bif.reqReady), 64'(0));
        @(negedge clock); chk("after release", 64'(bif.reqReady), 64'(1));

        // back-to-back writes with reqValid held
        @(posedge clock); #1;
        bif.reqValid = 1; bif.reqWrite = 1; bif.reqAddr = AW'(3); bif.reqData = 32'h33333333;
        @(negedge clock);
        @(posedge clock); #1;
        bif.reqAddr = AW'(4); bif.reqData = 32'h44444444;
        for (int i = 0; i < 20 && !bif.reqReady; i++) @(negedge clock);
        @(posedge clock); #1 bif.reqValid = 0;
        repeat (4) @(negedge clock);
        chk("slave3", 64'(slaveMem[3]), 64'h33333333);
        chk("slave4", 64'(slaveMem[4]), 64'h44444444);

        // highest valid slave, then out-of-range write/read
        send(1, 19, 32'hA5A5A5A5);
        repeat (3) @(negedge clock);
        chk("slave19", 64'(slaveMem[19]), 64'hA5A5A5A5);
        send(1, 20, 32'hFFFFFFFF);
        @(negedge clock);
        chk("oor wr enable", 64'(bif.busEnable), 64'(0));
        chk("oor wr strobe", 64'(bif.busWrite),  64'(0));
        repeat (2) @(negedge clock);
        send(0, 25, '0);
        @(negedge clock); chk("oor rd enable", 64'(bif.busEnable), 64'(0));
        repeat (2) @(negedge clock);
        chk("oor rd valid", 64'(bif.respValid), 64'(1));
        chk("oor rd data",  64'(bif.respData),  64'(0));
`ifdef REG_BUS_ERROR_EN
        chk("oor rd error", 64'(bif.respError), 64'(1));
`endif
        send(0, 19, '0);
        repeat (3) @(negedge clock);
        chk("rd19 data", 64'(bif.respData), 64'hA5A5A5A5);

        // reset during the Read bus cycle
        send(0, 5, '0);
        reset = 1;
        @(negedge clock); chk("rr c1 enable", 64'(bif.busEnable), 64'h20);
        @(posedge clock); #1 reset = 0;
        @(negedge clock);
        chk("rr enable",   64'(bif.busEnable), 64'(0));
        chk("rr valid",    64'(bif.respValid), 64'(0));
        chk("rr ready",    64'(bif.reqReady),  64'(1));
        chk("rr respData", 64'(bif.respData),  64'(0));
        sawResp = 0;
        repeat (6) begin
            @(negedge clock);
            if (bif.respValid) sawResp = 1;
        end
        chk("rr no resp", 64'(sawResp), 64'(0));

        // reset together with reqValid: not accepted
        @(posedge clock); #1;
        reset = 1; bif.reqValid = 1; bif.reqWrite = 1; bif.reqAddr = AW'(2); bif.reqData = 32'h1;
        @(posedge clock); #1;
        reset = 0; bif.reqValid = 0;
        @(negedge clock);
        chk("rv enable", 64'(bif.busEnable), 64'(0));
        chk("rv ready",  64'(bif.reqReady),  64'(1));

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
